// File: rtl/serial_add_sub_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_add_sub_pkg
// Brief    : Shared state encoding and default width for the bit-serial
//            adder/subtractor.
// Revision : 1.0 - initial release
// ============================================================================
package serial_add_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_add_sub_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : full_add_sub_cell
// Brief    : Combinational 1-bit add/subtract cell. b is inverted internally
//            when sub=1, so callers pass raw operand bits.
// Revision : 1.0 - initial release
// ============================================================================
module full_add_sub_cell (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_b_eff;

  assign w_b_eff = b ^ sub;
  assign s       = a ^ w_b_eff ^ cin;
  assign cout    = (a & w_b_eff) | (a & cin) | (w_b_eff & cin);

endmodule
`default_nettype wire

// File: rtl/serial_add_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : serial_add_sub
// Brief    : Bit-serial two's-complement adder/subtractor. Operands are
//            shifted LSB-first through one 1-bit cell; the result, final
//            carry and signed overflow are published together on completion.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_sum_sh;
  logic               r_sub;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_s;
  logic               w_c;

  full_add_sub_cell u_cell (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .sub  (r_sub),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_c)
  );

  // Sequencer: capture operands, step one bit per clock, publish on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // DONE behaves like IDLE for a new request, so back-to-back starts work.
          done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_sub   <= sub;
            r_carry <= sub;        // the +1 of a + ~b + 1
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          r_carry  <= w_c;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            // r_carry here is the carry into the MSB, w_c the carry out of it.
            result   <= {w_s, r_sum_sh[WIDTH-1:1]};
            cout     <= w_c;
            overflow <= r_carry ^ w_c;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= ST_DONE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_sub
// Brief    : Self-checking bench. An 8-bit instance runs directed vectors with
//            literal expectations; a 4-bit instance is swept exhaustively.
//            A cycle-level arithmetic model checks both every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, sub8, busy8, done8, cout8, ov8;
  logic [7:0] a8, b8, res8;
  logic       start4, sub4, busy4, done4, cout4, ov4;
  logic [3:0] a4, b4, res4;

  int checks   = 0;
  int failures = 0;
  bit ready    = 1'b0;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(res4), .cout(cout4), .overflow(ov4)
  );

  // Expected visible outputs of one instance, tracked as a countdown.
  typedef struct {
    bit busy, done, co, ov, sub;
    int res, rem, a, b;
  } mdl_t;

  mdl_t m8, m4;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Plain arithmetic: sum/difference modulo 2^w, carry-out, and signed overflow
  // from operand/result signs.
  function automatic void calc(input int w, input int a, input int b, input bit s,
                               output int res, output bit co, output bit ov);
    int mask, bb, full;
    bit sa, sb, sr;
    mask = (1 << w) - 1;
    bb   = s ? (~b & mask) : b;
    full = a + bb + (s ? 1 : 0);
    res  = full & mask;
    co   = ((full >> w) & 1) != 0;
    sa   = ((a >> (w-1)) & 1) != 0;
    sb   = ((b >> (w-1)) & 1) != 0;
    sr   = ((res >> (w-1)) & 1) != 0;
    ov   = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
  endfunction

  task automatic model_step(input int w, input bit r, input bit st, input bit s,
                            input int a, input int b, inout mdl_t m);
    if (r) begin
      m = '{default: 0};
    end else if (m.busy) begin
      m.rem--;
      if (m.rem == 0) begin
        m.busy = 1'b0;
        m.done = 1'b1;
        calc(w, m.a, m.b, m.sub, m.res, m.co, m.ov);
      end
    end else if (st) begin
      m.busy = 1'b1;
      m.done = 1'b0;
      m.rem  = w;
      m.a    = a;
      m.b    = b;
      m.sub  = s;
    end else begin
      m.done = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    model_step(8, rst, start8, sub8, int'(a8), int'(b8), m8);
    model_step(4, rst, start4, sub4, int'(a4), int'(b4), m4);
  end

  // Single compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (ready) begin
      chk("busy8", int'(busy8), int'(m8.busy));
      chk("done8", int'(done8), int'(m8.done));
      chk("result8", int'(res8), m8.res);
      chk("cout8", int'(cout8), int'(m8.co));
      chk("overflow8", int'(ov8), int'(m8.ov));
      chk("busy4", int'(busy4), int'(m4.busy));
      chk("done4", int'(done4), int'(m4.done));
      chk("result4", int'(res4), m4.res);
      chk("cout4", int'(cout4), int'(m4.co));
      chk("overflow4", int'(ov4), int'(m4.ov));
    end
  end

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic wait_done8(output int lat);
    lat = 0;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op8(input string nm, input bit s, input logic [7:0] a,
                         input logic [7:0] b, input int er, input bit ec, input bit eo);
    int lat;
    @(negedge clk);
    sub8 = s; a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat);
    chk({nm, "_latency"}, lat, 8);
    chk({nm, "_result"}, int'(res8), er);
    chk({nm, "_cout"}, int'(cout8), int'(ec));
    chk({nm, "_overflow"}, int'(ov8), int'(eo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", int'(busy8), 0);
    chk("reset_done", int'(done8), 0);
    chk("reset_result", int'(res8), 0);
    chk("reset_cout", int'(cout8), 0);
    chk("reset_overflow", int'(ov8), 0);

    run_op8("add_3c_0f", 1'b0, 8'h3C, 8'h0F, 'h4B, 1'b0, 1'b0);
    run_op8("sub_10_01", 1'b1, 8'h10, 8'h01, 'h0F, 1'b1, 1'b0);
    run_op8("sub_00_01", 1'b1, 8'h00, 8'h01, 'hFF, 1'b0, 1'b0);
    run_op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 'h80, 1'b0, 1'b1);
    run_op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 'h00, 1'b1, 1'b0);

    // Start pulse mid-RUN must be ignored.
    @(negedge clk);
    sub8 = 1'b1; a8 = 8'h55; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'hAA; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = '0; b8 = '0;
    lat = 3;
    while (!done8 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("ignored_latency", lat, 8);
    chk("ignored_result", int'(res8), 'h33);
    chk("ignored_cout", int'(cout8), 1);

    // Back-to-back start issued during the DONE cycle.
    sub8 = 1'b0; a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    chk("b2b_busy", int'(busy8), 1);
    chk("b2b_done_drop", int'(done8), 0);
    wait_done8(lat);
    chk("b2b_latency", lat, 8);
    chk("b2b_result", int'(res8), 'h02);

    // Reset mid-operation: everything clears, no done pulse afterwards.
    @(negedge clk);
    sub8 = 1'b0; a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_done", int'(done8), 0);
    chk("abort_result", int'(res8), 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(done8), 0);
    end
    run_op8("after_abort", 1'b0, 8'h12, 8'h34, 'h46, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep; the compare process checks every cycle.
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          @(negedge clk);
          sub4 = s[0]; a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          lat = 0;
          while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
          end
          chk("sweep4_latency", lat, 4);
        end
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
